// File: rtl/spi_bus_arbiter_if.sv
// rtl/spi_bus_arbiter_if.sv - requester handshake and SPI pin bundle for spi_bus_arbiter
interface spi_bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] tx_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        rx_data;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NREQ-1:0]   ss_n;

    modport master (
        input  req, tx_data, miso,
        output gnt, done, rx_data, busy, sclk, mosi, ss_n
    );

    modport slave (
        output req, tx_data, miso,
        input  gnt, done, rx_data, busy, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin arbiter sharing one CPHA=0 SPI byte shifter
// Every output is a register; the winner is chosen in IDLE and owns the bus until GAP.
module spi_bus_arbiter #(
    parameter int   NREQ    = 4,
    parameter int   CLK_DIV = 4,
    parameter logic CPOL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    spi_bus_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [3:0]      edge_q, edge_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ss_n_q, ss_n_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            div_last;
    logic            any_req;
    logic [PW-1:0]   winner;
    logic [7:0]      win_byte;

    // Search starts just after the last winner, so it has the lowest priority.
    function automatic logic [PW-1:0] next_winner(input logic [NREQ-1:0] r,
                                                  input logic [PW-1:0]   p);
        logic [PW-1:0] w;
        logic          hit;
        int            c;
        w   = p;
        hit = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(p) + k) % NREQ;
            if (!hit && r[c]) begin
                w   = PW'(c);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    assign div_last = (div_q == DIV_LAST);
    assign any_req  = |bus.req;
    assign winner   = next_winner(bus.req, ptr_q);
    assign win_byte = bus.tx_data[8*winner +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            ptr_q     <= PTR_LAST;
            gnt_q     <= '0;
            ss_n_q    <= '1;
            done_q    <= '0;
            rx_data_q <= 8'h00;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            ss_n_q    <= ss_n_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        ptr_d   = ptr_q;
        if (state_q != S_IDLE) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_SETUP;
                    ptr_d   = winner;
                    div_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    state_d = S_SHIFT;
                    edge_d  = '0;
                end
            end
            // edge_q indexes the half-period; edges 2..16 open half-periods 1..15.
            S_SHIFT: begin
                if (div_last) begin
                    if (edge_q == 4'd15) state_d = S_HOLD;
                    else                 edge_d  = edge_q + 4'd1;
                end
            end
            S_HOLD:  if (div_last) state_d = S_GAP;
            S_GAP:   if (div_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        ss_n_d    = ss_n_q;
        done_d    = '0;
        rx_data_d = rx_data_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    ss_n_d         = '1;
                    ss_n_d[winner] = 1'b0;
                    tx_sh_d        = win_byte;
                    mosi_d         = win_byte[7];
                    rx_sh_d        = 8'h00;
                    sclk_d         = CPOL;
                end
            end
            // Leaving SETUP is the first leading edge, so it samples too.
            S_SETUP: begin
                if (div_last) begin
                    sclk_d  = ~CPOL;
                    rx_sh_d = {rx_sh_q[6:0], bus.miso};
                end
            end
            S_SHIFT: begin
                if (div_last && edge_q != 4'd15) begin
                    sclk_d = ~sclk_q;
                    if (!edge_q[0]) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                    end else begin
                        rx_sh_d = {rx_sh_q[6:0], bus.miso};
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    ss_n_d    = '1;
                    gnt_d     = '0;
                    done_d    = gnt_q;
                    rx_data_d = rx_sh_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.ss_n    = ss_n_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - scoreboard bench for spi_bus_arbiter, CPOL=0 and CPOL=1 instances
module tb_spi_bus_arbiter;
    localparam int NREQ = 4;

    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic [7:0] rx;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic loop0;
    logic [7:0] slave_byte;
    logic [7:0] sl_sh = 8'h00;
    logic sl_prev = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.NREQ(NREQ)) if0 ();
    spi_bus_arbiter_if #(.NREQ(NREQ)) if1 ();

    spi_bus_arbiter #(.NREQ(NREQ), .CLK_DIV(4), .CPOL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.master));
    spi_bus_arbiter #(.NREQ(NREQ), .CLK_DIV(4), .CPOL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.master));

    // Slave: presents bit 7 first, shifts on falling (trailing) SCLK while selected.
    always @(negedge clk) begin
        if (&if0.ss_n) begin
            sl_sh   <= slave_byte;
            sl_prev <= if0.sclk;
        end else begin
            if (sl_prev && !if0.sclk) sl_sh <= {sl_sh[6:0], 1'b0};
            sl_prev <= if0.sclk;
        end
    end

    assign if0.miso = loop0 ? if0.mosi : sl_sh[7];
    assign if1.miso = if1.mosi;

    logic [NREQ-1:0] m_gnt, m_ss_n, m_done;
    logic [7:0]      m_rx;
    logic            m_sclk, m_mosi, m_busy;
    assign m_gnt  = sel ? if1.gnt     : if0.gnt;
    assign m_ss_n = sel ? if1.ss_n    : if0.ss_n;
    assign m_done = sel ? if1.done    : if0.done;
    assign m_rx   = sel ? if1.rx_data : if0.rx_data;
    assign m_sclk = sel ? if1.sclk    : if0.sclk;
    assign m_mosi = sel ? if1.mosi    : if0.mosi;
    assign m_busy = sel ? if1.busy    : if0.busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Follows one transfer from the grant to the done cycle and scores it.
    task automatic observe(input int exp_gap, input bit drop);
        sb_t e;
        int hi, lo, lead;
        logic [7:0] mb;
        logic [NREQ-1:0] oh, lowpat;
        logic ok, prev, cpol;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e    = sb.pop_front();
        cpol = sel;
        oh   = '0;
        oh[e.idx] = 1'b1;
        lowpat = ~oh;
        hi = 0;
        do begin
            @(negedge clk);
            hi++;
        end while (m_ss_n == '1 && hi < 400);
        if (hi >= 400) begin
            check("grant_timeout", 32'd1, 32'd0);
            return;
        end
        if (exp_gap >= 0) check("ss_high_gap", hi, exp_gap);
        check("grant", m_gnt, oh);
        check("ss_low", m_ss_n, lowpat);
        if (drop) begin
            if (sel) begin
                if1.req = '0;
                if1.tx_data = ~if1.tx_data;
            end else begin
                if0.req = '0;
                if0.tx_data = ~if0.tx_data;
            end
        end
        lo = 1; lead = 0; mb = 8'h00; ok = 1'b1; prev = m_sclk;
        forever begin
            @(negedge clk);
            if (m_ss_n != lowpat || lo > 200) break;
            lo++;
            if (m_gnt != oh || m_done != '0) ok = 1'b0;
            if (prev == cpol && m_sclk != cpol) begin
                lead++;
                mb = {mb[6:0], m_mosi};
            end
            prev = m_sclk;
        end
        check("ss_low_cycles", lo, 72);
        check("leading_edges", lead, 8);
        check("mosi_byte", mb, e.tx);
        check("gnt_held", ok, 1'b1);
        check("ss_released", m_ss_n, 4'hF);
        check("gnt_released", m_gnt, 4'h0);
        check("done_pulse", m_done, oh);
        check("rx_data", m_rx, e.rx);
        check("sclk_idle", m_sclk, cpol);
    endtask

    initial begin
        bit no_done;
        int n;
        rst = 1'b1; sel = 1'b0; loop0 = 1'b1; slave_byte = 8'h00;
        if0.req = '0; if0.tx_data = '0; if1.req = '0; if1.tx_data = '0;
        #1;
        check("rst_gnt", if0.gnt, 4'h0);
        check("rst_ss_n", if0.ss_n, 4'hF);
        check("rst_done", if0.done, 4'h0);
        check("rst_rx", if0.rx_data, 8'h00);
        check("rst_busy", if0.busy, 1'b0);
        check("rst_sclk0", if0.sclk, 1'b0);
        check("rst_mosi", if0.mosi, 1'b0);
        check("rst_sclk1", if1.sclk, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Loopback A5 on requester 1; req and tx_data dropped after grant.
        @(negedge clk);
        if0.tx_data[15:8] = 8'hA5;
        if0.req = 4'b0010;
        sb.push_back('{1, 8'hA5, 8'hA5});
        observe(-1, 1'b1);
        @(negedge clk);
        check("done_one_cycle_t1", if0.done, 4'h0);

        // Slave returns 3C while requester 3 sends FF.
        loop0 = 1'b0;
        slave_byte = 8'h3C;
        if0.tx_data[31:24] = 8'hFF;
        if0.req = 4'b1000;
        sb.push_back('{3, 8'hFF, 8'h3C});
        observe(-1, 1'b0);
        if0.req = '0;
        @(negedge clk);
        check("done_one_cycle_t2", if0.done, 4'h0);
        check("rx_held", if0.rx_data, 8'h3C);

        // All four requesting after reset: 0,1,2,3,0 back to back.
        wait_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        loop0 = 1'b1;
        if0.tx_data = {8'h18, 8'h24, 8'h42, 8'h81};
        if0.req = 4'b1111;
        sb.push_back('{0, 8'h81, 8'h81});
        sb.push_back('{1, 8'h42, 8'h42});
        sb.push_back('{2, 8'h24, 8'h24});
        sb.push_back('{3, 8'h18, 8'h18});
        sb.push_back('{0, 8'h81, 8'h81});
        observe(-1, 1'b0);
        for (int i = 0; i < 4; i++) observe(5, 1'b0);
        if0.req = '0;

        // Requesters 0 and 2 alternate.
        wait_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if0.req = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{0, 8'h81, 8'h81});
            sb.push_back('{2, 8'h24, 8'h24});
        end
        observe(-1, 1'b0);
        for (int i = 0; i < 3; i++) observe(5, 1'b0);
        if0.req = '0;

        // Reset 30 cycles into a transfer aborts it without done.
        wait_idle();
        if0.req = 4'b0100;
        n = 0;
        while (if0.gnt == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_grant", if0.gnt, 4'b0100);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ss_n", if0.ss_n, 4'hF);
        check("abort_gnt", if0.gnt, 4'h0);
        check("abort_sclk", if0.sclk, 1'b0);
        check("abort_busy", if0.busy, 1'b0);
        @(negedge clk);
        if0.req = '0;
        rst = 1'b0;
        no_done = 1'b1;
        repeat (90) begin
            @(negedge clk);
            if (if0.done != '0) no_done = 1'b0;
        end
        check("abort_no_done", no_done, 1'b1);
        if0.req = 4'b0101;
        sb.push_back('{0, 8'h81, 8'h81});
        observe(-1, 1'b0);
        if0.req = '0;
        wait_idle();

        // CPOL=1 instance, loopback 5A.
        sel = 1'b1;
        @(negedge clk);
        check("cpol1_idle", if1.sclk, 1'b1);
        if1.tx_data[7:0] = 8'h5A;
        if1.req = 4'b0001;
        sb.push_back('{0, 8'h5A, 8'h5A});
        observe(-1, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Round-robin arbiter and byte sequencer that shares one SPI master datapath between `NREQ` requesters. Each requester has its own active-low slave select. The block grants the bus, shifts one byte MSB-first (CPHA=0 and selectable CPOL), and returns the received byte with a per-requester done pulse. It sits between local protocol clients and the board-level SPI pins.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period, ≥2.
- `CPOL`, 0: SCLK idle level. Data is always sampled on the leading edge (CPHA=0).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester transfer request (level).
- `tx_data`  in  8*NREQ  byte for requester i at bits [8i+7:8i].
- `gnt`  out  NREQ  one-hot grant, held for the whole transfer.
- `done`  out  NREQ  one-cycle pulse to the granted requester at transfer end.
- `rx_data`  out  8  last received byte, valid from the `done` cycle until the next `done`.
- `busy`  out  1  high in any state other than IDLE.
- `sclk`  out  1  SPI clock.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in.
- `ss_n`  out  NREQ  slave selects, active-low; at most one is low.

## Operation
- States are IDLE, SETUP, SHIFT, HOLD and GAP.
- **IDLE:** if any `req` bit is high, pick the winner by searching from `ptr+1` modulo NREQ.
  - Register `gnt[w]=1`, `ss_n[w]=0`, and `ptr=w`.
  - Load the shift register from the `tx_data` slice w.
  - Go to SETUP.
  - If no `req` bit is high, stay in IDLE.
- **SETUP:** lasts CLK_DIV cycles. `sclk=CPOL` and `mosi` = bit 7 of the loaded byte.
- **SHIFT:** 16 SCLK half-periods of CLK_DIV cycles each.
  - Odd (leading) edges sample `miso` into the receive shift register, LSB-in.
  - Even (trailing) edges drive the next TX bit onto `mosi`. After the 8th trailing edge, `sclk` is back at CPOL.
- **HOLD:** lasts CLK_DIV cycles with `ss_n[w]` still low. On exit, in the same edge:
  - `ss_n` goes all-ones and `gnt` goes to 0.
  - `done[w]` is set for 1 cycle and `rx_data` is loaded.
  - Go to GAP.
- **GAP:** lasts CLK_DIV cycles with everything deselected, then go to IDLE.
- **Request rules:**
  - `tx_data` is sampled only on the grant edge. Later changes are ignored.
  - Dropping `req` after the grant does not abort the transfer.
  - A `req` still high after `done` starts a new transfer; it re-arbitrates in IDLE after GAP.
- **Fairness:** the requester granted last has lowest priority at the next arbitration.
- **Reset values** (asynchronous, immediate, including mid-transfer):
  - `gnt=0`, `done=0`, `rx_data=8'h00`, `busy=0`.
  - `sclk=CPOL`, `mosi=0`, `ss_n` all ones.
  - State IDLE, `ptr=NREQ-1` (so requester 0 wins first).
  - An aborted transfer produces no `done`.
- **Internal widths:** divider counter `$clog2(CLK_DIV)` bits, wrapping at CLK_DIV-1; edge counter 4 bits (0..15); `ptr` `$clog2(NREQ)` bits, wrapping modulo NREQ.

## Timing
- Grant latency: `req` high before edge N gives `gnt` and `ss_n` low after edge N. IDLE is one cycle.
- `ss_n` low time is exactly 18*CLK_DIV cycles: 72 at CLK_DIV=4.
- First SCLK leading edge: CLK_DIV cycles after `ss_n` falls.
- `done` is high in the first cycle `ss_n` is high again.
- Back-to-back transfers: `ss_n` is high for CLK_DIV+1 cycles (GAP plus IDLE). The period is 19*CLK_DIV+1 cycles.
- `miso` is sampled on the `clk` edge that creates the leading SCLK edge. The slave must hold it stable for 1 cycle around that edge.
- All outputs are registered. None depends combinationally on any input.

## Test plan
Parameters: NREQ=4, CLK_DIV=4, CPOL=0 unless stated.
1. Loopback: `miso=mosi`, `req=0010`, `tx_data[15:8]=8'hA5`. Required response:
   - `gnt=0010` and `ss_n=1101` for 72 cycles.
   - `mosi` sequence 1,0,1,0,0,1,0,1.
   - 8 rising edges on `sclk`.
   - `done=0010` pulse and `rx_data=8'hA5`.
2. Slave model returns 8'h3C while requester 3 sends 8'hFF → `rx_data=8'h3C` and `done[3]` pulses once.
3. `req=1111` held right after reset → grant order 0,1,2,3,0, with `ss_n` high for 5 cycles between transfers.
4. `req[0]` and `req[2]` held continuously → grants alternate 0,2,0,2, and requester 0 is never granted twice in a row.
5. `rst` pulsed 30 cycles into a transfer → that cycle shows `ss_n=1111`, `gnt=0`, `sclk=0`, `busy=0`, with no `done`. After release, `req=0101` grants requester 0 first.
6. CPOL=1 instance, loopback 8'h5A → `sclk` idles high, 8 falling leading edges, `rx_data=8'h5A`.
